// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - round-robin arbiter sharing one register file between core (0) and debug (1)
// Grants one requester per cycle, muxes its fields onto the file, and registers the read data back.
module regfile_port_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_lock,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_rsa,
  input  logic [ADDR_W-1:0] req0_rta,
  input  logic [ADDR_W-1:0] req0_wta,
  input  logic [DATA_W-1:0] req0_wtd,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_lock,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_rsa,
  input  logic [ADDR_W-1:0] req1_rta,
  input  logic [ADDR_W-1:0] req1_wta,
  input  logic [DATA_W-1:0] req1_wtd,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rsd,
  output logic [DATA_W-1:0] rsp0_rtd,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rsd,
  output logic [DATA_W-1:0] rsp1_rtd,
  output logic [ADDR_W-1:0] rf_rsa,
  output logic [ADDR_W-1:0] rf_rta,
  output logic [ADDR_W-1:0] rf_wta,
  output logic [DATA_W-1:0] rf_wtd,
  output logic              rf_cnt,
  input  logic [DATA_W-1:0] rf_rsd,
  input  logic [DATA_W-1:0] rf_rtd,
  output logic              wr_zero_err
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt0, gnt1, sel_we;

  logic              rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_rsd_q, rsp0_rsd_d, rsp0_rtd_q, rsp0_rtd_d;
  logic [DATA_W-1:0] rsp1_rsd_q, rsp1_rsd_d, rsp1_rtd_q, rsp1_rtd_d;
  logic              wr_zero_err_q, wr_zero_err_d;

  // Grant is gated by rst_n so nothing reaches the file while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          gnt0 = ~ptr_q;
          gnt1 = ptr_q;
        end else begin
          gnt0 = req0_valid;
          gnt1 = req1_valid;
        end
      end
      OWN0:    gnt0 = req0_valid;
      OWN1:    gnt1 = req1_valid;
      default: ;
    endcase
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt0) begin
          if (req0_lock && (LOCK_MAX > 1)) begin
            state_d = OWN0;
            cnt_d   = CNT_W'(LOCK_MAX - 1);
          end else begin
            ptr_d = 1'b1;
          end
        end else if (gnt1) begin
          if (req1_lock && (LOCK_MAX > 1)) begin
            state_d = OWN1;
            cnt_d   = CNT_W'(LOCK_MAX - 1);
          end else begin
            ptr_d = 1'b0;
          end
        end
      end
      // Budget burns every owned cycle, granted or not.
      OWN0: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (!req0_lock || (cnt_q == CNT_W'(1))) begin
          state_d = IDLE;
          ptr_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      OWN1: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (!req1_lock || (cnt_q == CNT_W'(1))) begin
          state_d = IDLE;
          ptr_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rf_rsa = '0;
    rf_rta = '0;
    rf_wta = '0;
    rf_wtd = '0;
    sel_we = 1'b0;
    if (gnt0) begin
      rf_rsa = req0_rsa;
      rf_rta = req0_rta;
      rf_wta = req0_wta;
      rf_wtd = req0_wtd;
      sel_we = req0_we;
    end else if (gnt1) begin
      rf_rsa = req1_rsa;
      rf_rta = req1_rta;
      rf_wta = req1_wta;
      rf_wtd = req1_wtd;
      sel_we = req1_we;
    end
    // Register 0 is hardwired; writes to it are dropped and flagged.
    rf_cnt        = sel_we && (rf_wta != '0);
    wr_zero_err_d = sel_we && (rf_wta == '0);
  end

  always_comb begin
    rsp0_valid_d = gnt0;
    rsp1_valid_d = gnt1;
    rsp0_rsd_d   = gnt0 ? rf_rsd : rsp0_rsd_q;
    rsp0_rtd_d   = gnt0 ? rf_rtd : rsp0_rtd_q;
    rsp1_rsd_d   = gnt1 ? rf_rsd : rsp1_rsd_q;
    rsp1_rtd_d   = gnt1 ? rf_rtd : rsp1_rtd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= 1'b0;
      cnt_q         <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_rsd_q    <= '0;
      rsp0_rtd_q    <= '0;
      rsp1_rsd_q    <= '0;
      rsp1_rtd_q    <= '0;
      wr_zero_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_rsd_q    <= rsp0_rsd_d;
      rsp0_rtd_q    <= rsp0_rtd_d;
      rsp1_rsd_q    <= rsp1_rsd_d;
      rsp1_rtd_q    <= rsp1_rtd_d;
      wr_zero_err_q <= wr_zero_err_d;
    end
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_rsd    = rsp0_rsd_q;
  assign rsp0_rtd    = rsp0_rtd_q;
  assign rsp1_rsd    = rsp1_rsd_q;
  assign rsp1_rtd    = rsp1_rtd_q;
  assign wr_zero_err = wr_zero_err_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - directed table, reset sequences and randomized traffic for regfile_port_arbiter
module tb_regfile_port_arbiter;
  localparam int LM = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v[2], l[2], we[2];
  logic [4:0]  rsa[2], rta[2], wta[2];
  logic [31:0] wtd[2];

  logic        ready0, ready1, rsp0_valid, rsp1_valid, rf_cnt, wr_zero_err;
  logic [31:0] rsp0_rsd, rsp0_rtd, rsp1_rsd, rsp1_rtd, rf_wtd, rf_rsd, rf_rtd;
  logic [4:0]  rf_rsa, rf_rta, rf_wta;

  // Register file the arbiter drives
  logic [31:0] rf_mem [32];
  logic        clr_mem;
  assign rf_rsd = rf_mem[rf_rsa];
  assign rf_rtd = rf_mem[rf_rta];
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else if (rf_cnt) begin
      rf_mem[rf_wta] <= rf_wtd;
    end
  end

  regfile_port_arbiter #(.ADDR_W(5), .DATA_W(32), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v[0]), .req0_lock(l[0]), .req0_we(we[0]),
    .req0_rsa(rsa[0]), .req0_rta(rta[0]), .req0_wta(wta[0]), .req0_wtd(wtd[0]),
    .req0_ready(ready0),
    .req1_valid(v[1]), .req1_lock(l[1]), .req1_we(we[1]),
    .req1_rsa(rsa[1]), .req1_rta(rta[1]), .req1_wta(wta[1]), .req1_wtd(wtd[1]),
    .req1_ready(ready1),
    .rsp0_valid(rsp0_valid), .rsp0_rsd(rsp0_rsd), .rsp0_rtd(rsp0_rtd),
    .rsp1_valid(rsp1_valid), .rsp1_rsd(rsp1_rsd), .rsp1_rtd(rsp1_rtd),
    .rf_rsa(rf_rsa), .rf_rta(rf_rta), .rf_wta(rf_wta), .rf_wtd(rf_wtd), .rf_cnt(rf_cnt),
    .rf_rsd(rf_rsd), .rf_rtd(rf_rtd),
    .wr_zero_err(wr_zero_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: who owns the file, how many cycles of the burst are used, whose turn it is.
  int          owner, used, turn, last_g;
  logic        ersp_v[2];
  logic [31:0] ersd[2], ertd[2];
  logic        eerr;
  logic [31:0] exp_mem [32];

  task automatic model_reset();
    owner = -1; used = 0; turn = 0; last_g = -1; eerr = 1'b0;
    for (int r = 0; r < 2; r++) begin
      ersp_v[r] = 1'b0; ersd[r] = '0; ertd[r] = '0;
    end
  endtask

  task automatic cycle(input bit use_tab, input logic [1:0] tg, input logic tc);
    int   g;
    logic ecnt;
    @(negedge clk); #1;
    if (owner >= 0)          g = v[owner] ? owner : -1;
    else if (v[0] && v[1])   g = turn;
    else if (v[0])           g = 0;
    else if (v[1])           g = 1;
    else                     g = -1;
    ecnt = (g >= 0) && we[g] && (wta[g] != 5'd0);
    chk("ready", {ready1, ready0}, {g == 1, g == 0});
    chk("rf_cnt", rf_cnt, ecnt);
    if (g >= 0) begin
      chk("rf_addr", {rf_rsa, rf_rta, rf_wta}, {rsa[g], rta[g], wta[g]});
      chk("rf_wtd", rf_wtd, wtd[g]);
    end else begin
      chk("rf_idle", {rf_rsa, rf_rta, rf_wta, rf_wtd}, 64'd0);
    end
    if (use_tab) begin
      chk("tab_gnt", {ready1, ready0}, tg);
      chk("tab_cnt", rf_cnt, tc);
    end
    eerr = (g >= 0) && we[g] && (wta[g] == 5'd0);
    for (int r = 0; r < 2; r++) ersp_v[r] = (g == r);
    if (g >= 0) begin
      ersd[g] = exp_mem[rsa[g]];
      ertd[g] = exp_mem[rta[g]];
      if (ecnt) exp_mem[wta[g]] = wtd[g];
    end
    if (owner >= 0) begin
      used++;
      if (!l[owner] || used >= LM) begin
        turn  = 1 - owner;
        owner = -1;
      end
    end else if (g >= 0) begin
      if (l[g] && LM > 1) begin
        owner = g;
        used  = 1;
      end else begin
        turn = 1 - g;
      end
    end
    last_g = g;
    @(posedge clk); #1;
    chk("rsp_valid", {rsp1_valid, rsp0_valid}, {ersp_v[1], ersp_v[0]});
    chk("rsp0_rsd", rsp0_rsd, ersd[0]);
    chk("rsp0_rtd", rsp0_rtd, ertd[0]);
    chk("rsp1_rsd", rsp1_rsd, ersd[1]);
    chk("rsp1_rtd", rsp1_rtd, ertd[1]);
    chk("wr_zero_err", wr_zero_err, eerr);
  endtask

  task automatic set_req(input int r, input logic vv, input logic ll, input logic ww,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] wa,
                         input logic [31:0] wd);
    v[r] = vv; l[r] = ll; we[r] = ww; rsa[r] = ra; rta[r] = rb; wta[r] = wa; wtd[r] = wd;
  endtask

  task automatic new_req(input int r);
    v[r]   = ($urandom_range(0, 3) != 0);
    l[r]   = ($urandom_range(0, 2) == 0);
    we[r]  = 1'($urandom_range(0, 1));
    rsa[r] = 5'($urandom_range(0, 7));
    rta[r] = 5'($urandom_range(0, 7));
    wta[r] = 5'($urandom_range(0, 7));
    wtd[r] = $urandom;
  endtask

  typedef struct {
    logic v0, l0, we0; logic [4:0] rsa0, wta0; logic [31:0] wtd0;
    logic v1, l1, we1; logic [4:0] rsa1, wta1; logic [31:0] wtd1;
    logic [1:0] gnt; logic cnt;
  } vec_t;
  vec_t tab[14];

  initial begin
    tab[0]  = '{1,0,1,5'd0,5'd5,32'hDEADBEEF, 0,0,0,5'd0,5'd0,32'h0, 2'b01,1};
    tab[1]  = '{1,0,0,5'd5,5'd0,32'h0,        0,0,0,5'd0,5'd0,32'h0, 2'b01,0};
    tab[2]  = '{1,0,1,5'd1,5'd1,32'hA5A5A5A5, 1,0,0,5'd1,5'd0,32'h0, 2'b10,0};
    tab[3]  = '{1,0,1,5'd1,5'd1,32'hA5A5A5A5, 1,0,0,5'd1,5'd0,32'h0, 2'b01,1};
    tab[4]  = '{1,0,1,5'd1,5'd1,32'h5A5A5A5A, 1,0,0,5'd1,5'd0,32'h0, 2'b10,0};
    tab[5]  = '{1,0,1,5'd1,5'd1,32'h5A5A5A5A, 1,0,0,5'd1,5'd0,32'h0, 2'b01,1};
    tab[6]  = '{0,0,0,5'd0,5'd0,32'h0,        1,0,0,5'd1,5'd0,32'h0, 2'b10,0};
    tab[7]  = '{1,1,1,5'd2,5'd2,32'h22222222, 1,0,0,5'd2,5'd0,32'h0, 2'b01,1};
    tab[8]  = '{1,1,1,5'd2,5'd2,32'h22222222, 1,0,0,5'd2,5'd0,32'h0, 2'b01,1};
    tab[9]  = '{1,1,1,5'd2,5'd2,32'h22222222, 1,0,0,5'd2,5'd0,32'h0, 2'b01,1};
    tab[10] = '{1,1,1,5'd2,5'd2,32'h22222222, 1,0,0,5'd2,5'd0,32'h0, 2'b01,1};
    tab[11] = '{1,1,1,5'd2,5'd2,32'h22222222, 1,0,0,5'd2,5'd0,32'h0, 2'b10,0};
    tab[12] = '{0,0,0,5'd0,5'd0,32'h0,        1,0,1,5'd0,5'd0,32'h12345678, 2'b10,0};
    tab[13] = '{0,0,0,5'd0,5'd0,32'h0,        1,0,0,5'd0,5'd0,32'h0, 2'b10,0};

    for (int i = 0; i < 32; i++) exp_mem[i] = '0;
    model_reset();

    // Reset held with both requesters writing
    clr_mem = 1'b1;
    rst_n   = 1'b0;
    set_req(0, 1, 0, 1, 5'd1, 5'd2, 5'd5, 32'hAAAA0000);
    set_req(1, 1, 0, 1, 5'd3, 5'd4, 5'd6, 32'hBBBB0000);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready", {ready1, ready0}, 2'b00);
    chk("rst_rf_cnt", rf_cnt, 1'b0);
    chk("rst_rf_bus", {rf_rsa, rf_rta, rf_wta, rf_wtd}, 64'd0);
    chk("rst_rsp", {rsp1_valid, rsp0_valid, wr_zero_err}, 3'b000);
    chk("rst_rsp_data", {rsp0_rsd, rsp1_rtd}, 64'd0);
    @(posedge clk); #1;
    clr_mem = 1'b0;
    rst_n   = 1'b1;
    set_req(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0);
    set_req(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0);
    cycle(1, 2'b01, 1'b0);
    v[0] = 1'b0;
    cycle(1, 2'b10, 1'b0);

    // Directed vectors: write/read-back, alternation, lock burst, zero-register write
    for (int i = 0; i < 14; i++) begin
      set_req(0, tab[i].v0, tab[i].l0, tab[i].we0, tab[i].rsa0, 5'd0, tab[i].wta0, tab[i].wtd0);
      set_req(1, tab[i].v1, tab[i].l1, tab[i].we1, tab[i].rsa1, 5'd5, tab[i].wta1, tab[i].wtd1);
      cycle(1, tab[i].gnt, tab[i].cnt);
    end

    // Reset in the second cycle of an OWN0 burst
    set_req(0, 1, 1, 1, 5'd3, 5'd0, 5'd3, 32'h33333333);
    set_req(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0);
    cycle(1, 2'b01, 1'b1);
    set_req(0, 1, 1, 1, 5'd3, 5'd0, 5'd3, 32'h44444444);
    @(negedge clk); #1;
    chk("own_ready", {ready1, ready0}, 2'b01);
    chk("own_cnt", rf_cnt, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", rf_cnt, 1'b0);
    chk("mid_rst_ready", {ready1, ready0}, 2'b00);
    chk("mid_rst_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
    @(posedge clk); #1;
    chk("mid_rst_hold", {rsp1_valid, rsp0_valid, wr_zero_err, rf_cnt}, 4'b0000);
    rst_n = 1'b1;
    model_reset();
    set_req(0, 1, 0, 0, 5'd3, 5'd1, 5'd0, 32'h0);
    set_req(1, 1, 0, 0, 5'd3, 5'd2, 5'd0, 32'h0);
    cycle(1, 2'b01, 1'b0);
    cycle(1, 2'b10, 1'b0);

    // Randomized traffic; fields are held until the request is granted
    for (int n = 0; n < 600; n++) begin
      for (int r = 0; r < 2; r++) if (!v[r] || last_g == r) new_req(r);
      cycle(0, 2'b00, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
